// File: rtl/jtag_reg_bridge.sv
// rtl/jtag_reg_bridge.sv - debug request to GPR access bridge with optional core-halt handshake
// Define JTAG_BRIDGE_HALT_EN to enable the HALT_WAIT handshake and timeout error.
module jtag_reg_bridge #(
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [4:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  output logic        halt_req_o,
  input  logic        halted_i,
  output logic        jtag_we_o,
  output logic [4:0]  jtag_addr_o,
  output logic [31:0] jtag_wdata_o,
  input  logic [31:0] jtag_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      state_q;
  logic        we_q;
  logic [4:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;

`ifdef JTAG_BRIDGE_HALT_EN
  logic [15:0] cnt_q;
  logic [16:0] cnt_d;

  assign cnt_d = {1'b0, cnt_q} + 17'd1;
`else
  logic unused_cfg;

  assign unused_cfg = halted_i ^ HALT_TIMEOUT[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= 5'd0;
      wdata_q     <= 32'd0;
      resp_data_q <= 32'd0;
      resp_err_q  <= 1'b0;
`ifdef JTAG_BRIDGE_HALT_EN
      cnt_q       <= 16'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
`ifdef JTAG_BRIDGE_HALT_EN
            cnt_q       <= 16'd0;
            state_q     <= S_HALT_WAIT;
`else
            state_q     <= S_ACCESS;
`endif
          end
        end
        S_HALT_WAIT: begin
`ifdef JTAG_BRIDGE_HALT_EN
          // A halt acknowledge on the timeout cycle still wins over the error.
          if (halted_i) begin
            state_q <= S_ACCESS;
          end else if (cnt_d == 17'(HALT_TIMEOUT)) begin
            resp_err_q  <= 1'b1;
            resp_data_q <= 32'd0;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_d[15:0];
          end
`else
          state_q <= S_IDLE;
`endif
        end
        S_ACCESS: begin
          resp_data_q <= we_q ? 32'd0 : jtag_rdata_i;
          resp_err_q  <= 1'b0;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state so reset clears them at once.
  assign req_ready_o  = (state_q == S_IDLE) && !rst;
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
`ifdef JTAG_BRIDGE_HALT_EN
  assign halt_req_o   = (state_q != S_IDLE);
`else
  assign halt_req_o   = 1'b0;
`endif
  assign jtag_we_o    = (state_q == S_ACCESS) && we_q && (addr_q != 5'd0);
  assign jtag_addr_o  = addr_q;
  assign jtag_wdata_o = wdata_q;

endmodule

// File: tb/tb_jtag_reg_bridge.sv
// tb/tb_jtag_reg_bridge.sv - directed self-checking bench for jtag_reg_bridge
module tb_jtag_reg_bridge;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [4:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic        halt_req_o;
  logic        halted_i;
  logic        jtag_we_o;
  logic [4:0]  jtag_addr_o;
  logic [31:0] jtag_wdata_o;
  logic [31:0] jtag_rdata_i;

`ifdef JTAG_BRIDGE_HALT_EN
  localparam int RESP_LAT = 2;
`else
  localparam int RESP_LAT = 1;
`endif

  int total;
  int bad;
  int we_cnt;
  logic [4:0]  we_addr;
  logic [31:0] we_data;
  int lat;
  int base;
  logic [31:0] held_data;

  jtag_reg_bridge #(.HALT_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_err_o   (resp_err_o),
    .halt_req_o   (halt_req_o),
    .halted_i     (halted_i),
    .jtag_we_o    (jtag_we_o),
    .jtag_addr_o  (jtag_addr_o),
    .jtag_wdata_o (jtag_wdata_o),
    .jtag_rdata_i (jtag_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file stand-in: GPR0 reads 0, GPR5 a fixed pattern, others tagged by index.
  assign jtag_rdata_i = (jtag_addr_o == 5'd0) ? 32'd0 :
                        (jtag_addr_o == 5'd5) ? 32'h1234_5678 :
                        (32'hA5A5_0000 | {27'd0, jtag_addr_o});

  always @(negedge clk) begin
    if (jtag_we_o) begin
      we_cnt  = we_cnt + 1;
      we_addr = jtag_addr_o;
      we_data = jtag_wdata_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic we, input logic [4:0] a, input logic [31:0] d);
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = d;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = 5'd0;
    req_wdata_i = 32'd0;
  endtask

  task automatic wait_resp(output int l);
    bit found;
    found = 1'b0;
    l = 99;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (resp_valid_o) begin
        l = i;
        found = 1'b1;
      end
    end
  endtask

  task automatic release_resp();
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; we_cnt = 0;
    we_addr = 5'd0; we_data = 32'd0;
    rst = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 5'd0; req_wdata_i = 32'd0;
    resp_ready_i = 1'b0;
    halted_i = 1'b1;

    #3;
    check("rst_ready", {31'd0, req_ready_o}, 32'd0);
    check("rst_valid", {31'd0, resp_valid_o}, 32'd0);
    check("rst_halt", {31'd0, halt_req_o}, 32'd0);
    check("rst_we", {31'd0, jtag_we_o}, 32'd0);
    check("rst_data", resp_data_o, 32'd0);
    check("rst_err", {31'd0, resp_err_o}, 32'd0);
    check("rst_addr", {27'd0, jtag_addr_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_ready", {31'd0, req_ready_o}, 32'd1);

    // Write GPR5 with core already halted.
    accept(1'b1, 5'd5, 32'hDEAD_BEEF);
    check("wr_ready_busy", {31'd0, req_ready_o}, 32'd0);
    wait_resp(lat);
    check("wr_lat", lat, RESP_LAT);
    check("wr_we_cnt", we_cnt, 1);
    check("wr_we_addr", {27'd0, we_addr}, 32'd5);
    check("wr_we_data", we_data, 32'hDEAD_BEEF);
    check("wr_err", {31'd0, resp_err_o}, 32'd0);
    check("wr_data", resp_data_o, 32'd0);
`ifdef JTAG_BRIDGE_HALT_EN
    check("wr_halt_req", {31'd0, halt_req_o}, 32'd1);
`endif
    release_resp();
    check("wr_done_valid", {31'd0, resp_valid_o}, 32'd0);
    check("wr_done_halt", {31'd0, halt_req_o}, 32'd0);

    // Reads: GPR5, GPR9, GPR0.
    accept(1'b0, 5'd5, 32'h0);
    wait_resp(lat);
    check("rd5_lat", lat, RESP_LAT);
    check("rd5_data", resp_data_o, 32'h1234_5678);
    check("rd5_err", {31'd0, resp_err_o}, 32'd0);
    release_resp();
    accept(1'b0, 5'd9, 32'hFFFF_FFFF);
    wait_resp(lat);
    check("rd9_data", resp_data_o, 32'hA5A5_0009);
    release_resp();
    accept(1'b0, 5'd0, 32'h0);
    wait_resp(lat);
    check("rd0_data", resp_data_o, 32'd0);
    release_resp();
    check("rd_we_cnt", we_cnt, 1);

    // Write GPR0: no strobe; response held while a second request is ignored.
    accept(1'b1, 5'd0, 32'h5555_AAAA);
    wait_resp(lat);
    check("w0_lat", lat, RESP_LAT);
    check("w0_err", {31'd0, resp_err_o}, 32'd0);
    check("w0_wdata", jtag_wdata_o, 32'h5555_AAAA);
    held_data = resp_data_o;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 5'd7; req_wdata_i = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", {31'd0, resp_valid_o}, 32'd1);
      check("hold_data", resp_data_o, held_data);
      check("hold_ready", {31'd0, req_ready_o}, 32'd0);
      check("hold_addr", {27'd0, jtag_addr_o}, 32'd0);
    end
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 5'd0; req_wdata_i = 32'd0;
    release_resp();
    tick(); tick();
    check("w0_no_second", {31'd0, resp_valid_o}, 32'd0);
    check("w0_idle_ready", {31'd0, req_ready_o}, 32'd1);
    check("w0_we_cnt", we_cnt, 1);

    // Core never halts.
    halted_i = 1'b0;
    base = we_cnt;
    accept(1'b1, 5'd7, 32'h7777_0007);
    wait_resp(lat);
`ifdef JTAG_BRIDGE_HALT_EN
    check("to_lat", lat, 4);
    check("to_err", {31'd0, resp_err_o}, 32'd1);
    check("to_data", resp_data_o, 32'd0);
    check("to_we_cnt", we_cnt, base);
    check("to_halt_req", {31'd0, halt_req_o}, 32'd1);
`else
    check("nohalt_lat", lat, 1);
    check("nohalt_err", {31'd0, resp_err_o}, 32'd0);
    check("nohalt_we_cnt", we_cnt, base + 1);
    check("nohalt_halt_req", {31'd0, halt_req_o}, 32'd0);
`endif
    release_resp();
    check("to_done_halt", {31'd0, halt_req_o}, 32'd0);

`ifdef JTAG_BRIDGE_HALT_EN
    // Halt acknowledge arrives on the fourth (timeout) HALT_WAIT cycle.
    base = we_cnt;
    accept(1'b1, 5'd8, 32'h8888_0008);
    tick(); tick(); tick();
    halted_i = 1'b1;
    wait_resp(lat);
    check("prio_lat", lat, 2);
    check("prio_err", {31'd0, resp_err_o}, 32'd0);
    check("prio_we_cnt", we_cnt, base + 1);
    release_resp();
    halted_i = 1'b0;
`endif

    // Reset right after accept (HALT_WAIT, or ACCESS without the handshake).
    base = we_cnt;
    accept(1'b1, 5'd3, 32'h3333_0003);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, req_ready_o}, 32'd0);
    check("mid_rst_halt", {31'd0, halt_req_o}, 32'd0);
    check("mid_rst_we", {31'd0, jtag_we_o}, 32'd0);
    check("mid_rst_addr", {27'd0, jtag_addr_o}, 32'd0);
    check("mid_rst_wdata", jtag_wdata_o, 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("mid_rst_no_resp", {31'd0, resp_valid_o}, 32'd0);
    check("mid_rst_no_write", we_cnt, base);
    halted_i = 1'b1;
    accept(1'b1, 5'd3, 32'h3333_0003);
    wait_resp(lat);
    check("post_rst_lat", lat, RESP_LAT);
    check("post_rst_we_cnt", we_cnt, base + 1);
    check("post_rst_we_data", we_data, 32'h3333_0003);
    release_resp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_reg_bridge.md
JTAG_REG_BRIDGE -- requirements
Module: jtag_reg_bridge

Interface
REQ-001 Parameter: HALT_TIMEOUT, 255, max cycles spent in HALT_WAIT before error response; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid_i  input  1  debug request present.
REQ-005 req_ready_o  output  1  bridge accepts request; high only in IDLE.
REQ-006 req_we_i  input  1  1 = register write, 0 = register read.
REQ-007 req_addr_i  input  5  target GPR index.
REQ-008 req_wdata_i  input  32  write data.
REQ-009 resp_valid_o  output  1  response present.
REQ-010 resp_ready_i  input  1  response consumer ready.
REQ-011 resp_data_o  output  32  read data; 0 for writes and errors.
REQ-012 resp_err_o  output  1  halt timeout occurred.
REQ-013 halt_req_o  output  1  request core halt.
REQ-014 halted_i  input  1  core halted acknowledge.
REQ-015 jtag_we_o  output  1  register-file debug write enable.
REQ-016 jtag_addr_o  output  5  register-file debug address.
REQ-017 jtag_wdata_o  output  32  register-file debug write data.
REQ-018 jtag_rdata_i  input  32  register-file debug read data, combinational from jtag_addr_o.

Function
REQ-019 FSM states SHALL be IDLE, HALT_WAIT, ACCESS, RESP; one state per cycle minimum.
REQ-020 Request accepted at rising edge with req_valid_i & req_ready_o; we/addr/wdata latched into internal registers; IDLE -> HALT_WAIT.
REQ-021 req_valid_i outside IDLE SHALL be ignored (no accept, no latch).
REQ-022 halt_req_o SHALL be 1 in HALT_WAIT, ACCESS, RESP; 0 in IDLE.
REQ-023 HALT_WAIT: halted_i=1 sampled -> ACCESS next cycle; counter increments each HALT_WAIT cycle, cleared on entry.
REQ-024 Counter reaching HALT_TIMEOUT with halted_i=0 -> RESP with resp_err_o=1, resp_data_o=0, no register access; halted_i=1 on the timeout cycle takes priority (ACCESS).
REQ-025 jtag_addr_o SHALL equal latched address in all states; jtag_wdata_o equals latched wdata.
REQ-026 ACCESS lasts exactly one cycle; jtag_we_o=1 only in ACCESS for a write with latched address != 0; 0 otherwise.
REQ-027 Write to address 0 SHALL complete normally (resp_err_o=0), no jtag_we_o pulse.
REQ-028 Read: jtag_rdata_i captured at the ACCESS->RESP edge into resp_data_o; address 0 returns value presented (0 from register file).
REQ-029 RESP: resp_valid_o=1 and resp_data_o/resp_err_o stable until resp_ready_i=1 sampled; then -> IDLE, resp_valid_o=0.
REQ-030 Latency with halted_i already 1: accept at edge N, ACCESS after edge N+1, resp_valid_o high after edge N+2.
REQ-031 halted_i dropping after ACCESS entered SHALL NOT abort the transaction.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, counter 0, latched fields 0, resp_data_o=0, resp_err_o=0, resp_valid_o=0, halt_req_o=0, jtag_we_o=0, req_ready_o=0 while rst=1, 1 in IDLE after release.
REQ-033 Reset mid-transaction SHALL discard it with no jtag_we_o pulse and no response.

Configuration
REQ-034 Macro JTAG_BRIDGE_HALT_EN defined: halt handshake per REQ-022..024.
REQ-035 Macro undefined: HALT_WAIT not entered (IDLE -> ACCESS), halt_req_o tied 0, halted_i ignored, resp_err_o always 0, counter absent.

Verification
REQ-036 halted_i=1 held, write addr 5 data 0xDEADBEEF -> one-cycle jtag_we_o pulse, addr 5, data 0xDEADBEEF; response err=0, data 0.
REQ-037 Read addr 5 with jtag_rdata_i=0x12345678 -> resp_data_o=0x12345678, resp_valid_o two edges after accept.
REQ-038 HALT_TIMEOUT=4, halted_i=0 -> resp_err_o=1 after 4 HALT_WAIT cycles, no jtag_we_o, halt_req_o drops after resp_ready_i.
REQ-039 Write addr 0 -> no jtag_we_o, err=0; resp_ready_i=0 for 3 cycles -> response held stable, second req_valid_i ignored.
REQ-040 Assert rst during ACCESS-preceding HALT_WAIT -> all outputs reset immediately; no write occurs; next request completes normally.
